// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the execute/writeback slice.
//   - DATA_W_DEF / ADDR_W_DEF / OP_W_DEF : default widths (32-bit words, 8 regs)
//   - OP_ADD .. OP_MUL                   : 3-bit opcode encodings
//   - stage_state_e                      : writeback stage FSM states
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned OP_W_DEF   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Unsigned shift-add multiplier, one multiplier bit per clock, W iterations.
// Only the low W bits of the product are kept.
//   clk, rst : clock, synchronous active-high reset
//   start    : load a/b and begin (ignored state is overwritten)
//   a, b     : multiplicand / multiplier, sampled on start
//   busy     : iterations in progress
//   done     : final iteration cycle; product is valid during this cycle
//   product  : low W bits of a*b (combinational, valid with done)
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(W);

    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     acc;
    logic [W-1:0]     partial;
    logic [CNT_W-1:0] count;

    // product already includes the current iteration's partial sum, so the
    // parent can write it on the same edge that retires the last iteration.
    always_comb begin
        partial = mplier[0] ? mcand : '0;
        product = acc + partial;
        done    = busy && (count == CNT_W'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
// Execute/writeback stage fed by the register file read ports. Computes one
// result per accepted op and pulses the register file write port once.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready low while rst or MUL busy)
//   in_op, in_rd        : opcode (ADD SUB AND OR XOR SLL SRL MUL), dest reg
//   in_a, in_b          : operands
//   wr_data/addr/en     : register file write port (wr_en one-cycle pulse)
//   flag_zero/carry     : flags of the last written result
// Optional feature macro ALU_MUL_EN: op 111 runs a 32-cycle shift-add
// multiply through seq_multiplier; otherwise op 111 is a single-cycle no-op.
// ---------------------------------------------------------------------------
module alu_writeback_stage
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              flag_zero,
    output logic              flag_carry
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    stage_state_e state;
    stage_state_e stateNext;

    logic              accept;
    logic              isMul;
    logic [DATA_W:0]   sumExt;
    logic [DATA_W:0]   diffExt;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;

    assign accept = in_valid & in_ready;
    assign isMul  = (in_op == OP_W'(OP_MUL));

`ifdef ALU_MUL_EN
    logic              mulStart;
    logic              mulBusy;
    logic              mulDone;
    logic [DATA_W-1:0] mulProduct;
    logic [ADDR_W-1:0] mulRd;

    assign mulStart = accept & isMul;

    // Destination is held here since in_rd may change while the multiply runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mulRd <= '0;
        end else if (mulStart) begin
            mulRd <= in_rd;
        end
    end

    seq_multiplier #(.W(DATA_W)) uMul (
        .clk     (clk),
        .rst     (rst),
        .start   (mulStart),
        .a       (in_a),
        .b       (in_b),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (mulProduct)
    );
`endif

    // Single-cycle ALU path; borrow is the MSB of the widened subtraction.
    always_comb begin
        sumExt    = {1'b0, in_a} + {1'b0, in_b};
        diffExt   = {1'b0, in_a} - {1'b0, in_b};
        aluResult = '0;
        aluCarry  = 1'b0;
        case (in_op)
            OP_W'(OP_ADD): begin
                aluResult = sumExt[DATA_W-1:0];
                aluCarry  = sumExt[DATA_W];
            end
            OP_W'(OP_SUB): begin
                aluResult = diffExt[DATA_W-1:0];
                aluCarry  = diffExt[DATA_W];
            end
            OP_W'(OP_AND): aluResult = in_a & in_b;
            OP_W'(OP_OR):  aluResult = in_a | in_b;
            OP_W'(OP_XOR): aluResult = in_a ^ in_b;
            OP_W'(OP_SLL): aluResult = in_a << in_b[SHAMT_W-1:0];
            OP_W'(OP_SRL): aluResult = in_a >> in_b[SHAMT_W-1:0];
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM: next state
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
`ifdef ALU_MUL_EN
                if (accept && isMul) begin
                    stateNext = ST_MUL;
                end
`endif
            end
            ST_MUL: begin
`ifdef ALU_MUL_EN
                if (mulDone || !mulBusy) begin
                    stateNext = ST_IDLE;
                end
`else
                stateNext = ST_IDLE;
`endif
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state == ST_IDLE) && !rst;
    end

    // Writeback port and flags; everything holds unless a result retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accept && !isMul) begin
                wr_en      <= 1'b1;
                wr_data    <= aluResult;
                wr_addr    <= in_rd;
                flag_zero  <= (aluResult == '0);
                flag_carry <= aluCarry;
            end
`ifdef ALU_MUL_EN
            if (state == ST_MUL && mulDone) begin
                wr_en      <= 1'b1;
                wr_data    <= mulProduct;
                wr_addr    <= mulRd;
                flag_zero  <= (mulProduct == '0);
                flag_carry <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback_stage
// Self-checking bench: directed vectors followed by random traffic, compared
// every cycle against a transaction-level reference (result + due cycle).
// Honours ALU_MUL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] wr_data;
    logic [2:0]  wr_addr;
    logic        wr_en;
    logic        flag_zero;
    logic        flag_carry;

    always #5 clk = ~clk;

    alu_writeback_stage #(.DATA_W(32), .ADDR_W(3), .OP_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_a       (in_a),
        .in_b       (in_b),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;

    // Reference state: one outstanding result with the cycle it must appear.
    int unsigned cyc       = 0;
    int unsigned busyUntil = 0;
    bit          pendValid = 1'b0;
    int unsigned pendCycle = 0;
    logic [31:0] pendData  = '0;
    logic [2:0]  pendAddr  = '0;
    bit          pendCarry = 1'b0;
    logic        mEn       = 1'b0;
    logic [31:0] mData     = '0;
    logic [2:0]  mAddr     = '0;
    logic        mZero     = 1'b0;
    logic        mCarry    = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic void refOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit c, output bit writes,
                                  output int unsigned lat);
        longint unsigned wide;
        r      = '0;
        c      = 1'b0;
        writes = 1'b1;
        lat    = 1;
        case (op)
            3'd0: begin
                wide = 64'(a) + 64'(b);
                r    = wide[31:0];
                c    = wide[32];
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << (b % 32);
            3'd6: r = a >> (b % 32);
            default: begin
                if (MUL_EN) begin
                    wide = 64'(a) * 64'(b);
                    r    = wide[31:0];
                    lat  = 33;
                end else begin
                    writes = 1'b0;
                end
            end
        endcase
    endfunction

    // One clock cycle: drive, check this cycle's outputs, advance the model.
    task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [2:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        bit          c;
        bit          w;
        int unsigned lat;
        bit          rdy;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_op    = op;
        in_rd    = rd;
        in_a     = a;
        in_b     = b;
        #1;
        rdy = !r && (cyc >= busyUntil);
        checkVal("in_ready",   32'(in_ready),   32'(rdy));
        checkVal("wr_en",      32'(wr_en),      32'(mEn));
        checkVal("wr_data",    wr_data,         mData);
        checkVal("wr_addr",    32'(wr_addr),    32'(mAddr));
        checkVal("flag_zero",  32'(flag_zero),  32'(mZero));
        checkVal("flag_carry", 32'(flag_carry), 32'(mCarry));
        mEn = 1'b0;
        if (r) begin
            pendValid = 1'b0;
            busyUntil = 0;
            mData     = '0;
            mAddr     = '0;
            mZero     = 1'b0;
            mCarry    = 1'b0;
        end else begin
            if (v && rdy) begin
                refOp(op, a, b, res, c, w, lat);
                if (lat > 1) busyUntil = cyc + lat;
                if (w) begin
                    pendValid = 1'b1;
                    pendCycle = cyc + lat;
                    pendData  = res;
                    pendAddr  = rd;
                    pendCarry = c;
                end
            end
            if (pendValid && pendCycle == cyc + 1) begin
                mEn       = 1'b1;
                mData     = pendData;
                mAddr     = pendAddr;
                mZero     = (pendData == 32'd0);
                mCarry    = pendCarry;
                pendValid = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(posedge clk);

        // Reset held with in_valid asserted: nothing accepted, outputs cleared.
        repeat (3) step(1'b1, 1'b1, 3'd0, 3'd1, 32'h1, 32'h2);

        // ADD with carry out.
        step(1'b0, 1'b1, 3'd0, 3'd3, 32'hACEDCAFE, 32'hDEADBEEF);
        idle();
        checkVal("t_add_data",  wr_data, 32'h8B9B89ED);
        checkVal("t_add_carry", 32'(flag_carry), 32'd1);

        // SUB to zero, then SUB with borrow.
        step(1'b0, 1'b1, 3'd1, 3'd7, 32'd5, 32'd5);
        step(1'b0, 1'b1, 3'd1, 3'd7, 32'd0, 32'd1);
        checkVal("t_sub_zero", 32'(flag_zero), 32'd1);
        idle();
        checkVal("t_sub_borrow", wr_data, 32'hFFFFFFFF);
        checkVal("t_sub_carry",  32'(flag_carry), 32'd1);

        // Back-to-back XOR / AND / SLL (shift amount wraps mod 32).
        step(1'b0, 1'b1, 3'd4, 3'd1, 32'hFFFF0000, 32'h0F0F0F0F);
        step(1'b0, 1'b1, 3'd2, 3'd2, 32'hFFFF0000, 32'h0F0F0F0F);
        checkVal("t_xor_data", wr_data, 32'hF0F00F0F);
        step(1'b0, 1'b1, 3'd5, 3'd4, 32'd1, 32'd35);
        checkVal("t_and_data", wr_data, 32'h0F0F0000);
        idle();
        checkVal("t_sll_data", wr_data, 32'h00000008);
        checkVal("t_sll_addr", 32'(wr_addr), 32'd4);

        // MUL with extra in_valid traffic while it runs.
        step(1'b0, 1'b1, 3'd7, 3'd6, 32'h0000FFFF, 32'h00010001);
        repeat (32) step(1'b0, 1'b1, 3'($urandom_range(6)), 3'($urandom_range(7)), $urandom, $urandom);
        idle();
`ifdef ALU_MUL_EN
        checkVal("t_mul_en",   32'(wr_en), 32'd1);
        checkVal("t_mul_data", wr_data, 32'hFFFFFFFF);
        checkVal("t_mul_addr", 32'(wr_addr), 32'd6);
`endif
        idle();

        // Reset in the middle of a MUL: aborted, no write afterwards.
        step(1'b0, 1'b1, 3'd7, 3'd5, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) idle();
        step(1'b1, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        repeat (40) idle();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic        r;
            logic        v;
            logic [31:0] a;
            logic [31:0] b;
            r = ($urandom_range(99) < 2);
            v = ($urandom_range(9) < 8);
            a = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
            b = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            if ($urandom_range(7) == 0) b = a;
            step(r, v, 3'($urandom_range(7)), 3'($urandom_range(7)), a, b);
        end
        repeat (40) idle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
